// File: rtl/dmem_pkg.sv
// Shared types for the pipelined data memory: word/byte-enable types, the
// response record carried through the latency pipe, and the byte-lane mask helper.
package dmem_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  be_t;

    typedef struct packed {
        logic  valid;
        logic  err;
        word_t rdata;
    } resp_t;

    function automatic word_t be2mask(be_t be);
        word_t mask;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// DEPTH x 32 single-port synchronous RAM with per-byte write enables.
// Read data is registered and only updated by read accesses.
module dmem_sram
    import dmem_pkg::*;
#(
    parameter int DEPTH = 8192,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          HCLK,
    input  logic          cs,
    input  logic          we,
    input  be_t           be,
    input  logic [AW-1:0] addr,
    input  word_t         wdata,
    output word_t         rdata
);

    word_t mem [DEPTH];
    word_t rdata_reg;

    always_ff @(posedge HCLK) begin
        if (cs) begin
            if (we) begin
                mem[addr] <= (mem[addr] & ~be2mask(be)) | (wdata & be2mask(be));
            end else begin
                rdata_reg <= mem[addr];
            end
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/data_memory_pipelined.sv
// RI5CY LSU slave (req/gnt/rvalid) over a byte-writable RAM with address-window
// decode, error responses, grant stalling and a configurable response latency.
module data_memory_pipelined
    import dmem_pkg::*;
#(
    parameter word_t DMEM_ADDR_LOW  = 32'h0010_0000,
    parameter word_t DMEM_ADDR_HIGH = 32'h0010_8000,
    parameter int    DEPTH          = 8192,
    parameter int    READ_LATENCY   = 1,
    parameter word_t ERR_RDATA      = 32'h0000_0000
) (
    input  logic  HCLK,
    input  logic  HRESETn,
    input  logic  data_req,
    input  logic  data_sel,
    input  word_t data_addr,
    input  logic  data_write,
    input  be_t   data_be,
    input  word_t data_wdata,
    input  logic  stall_i,
    output logic  data_gnt,
    output logic  data_rvalid,
    output word_t data_rdata,
    output logic  data_err
);

    localparam int AW = $clog2(DEPTH);

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("data_memory_pipelined: READ_LATENCY must be in 1..4");
    end

    word_t         addr_offset;
    logic [AW-1:0] ram_addr;
    logic          in_range;
    logic          ram_cs;
    word_t         ram_rdata;
    logic          addr_unused;

    assign data_gnt    = data_req & data_sel & ~stall_i;
    assign in_range    = (data_addr >= DMEM_ADDR_LOW) && (data_addr < DMEM_ADDR_HIGH);
    assign addr_offset = data_addr - DMEM_ADDR_LOW;
    assign ram_addr    = addr_offset[AW+1:2];
    assign addr_unused = ^{addr_offset[31:AW+2], addr_offset[1:0]};
    // Out-of-window accesses never touch the RAM, even though the index would alias.
    assign ram_cs      = data_gnt & in_range;

    dmem_sram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .HCLK  (HCLK),
        .cs    (ram_cs),
        .we    (data_write),
        .be    (data_be),
        .addr  (ram_addr),
        .wdata (data_wdata),
        .rdata (ram_rdata)
    );

    // Stage 0 pairs flags registered at the grant edge with the RAM's own output register.
    logic  s0_valid_reg;
    logic  s0_err_reg;
    logic  s0_read_reg;
    resp_t stage0;
    resp_t resp_out;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s0_valid_reg <= 1'b0;
            s0_err_reg   <= 1'b0;
            s0_read_reg  <= 1'b0;
        end else begin
            s0_valid_reg <= data_gnt;
            s0_err_reg   <= data_gnt & ~in_range;
            s0_read_reg  <= data_gnt & in_range & ~data_write;
        end
    end

    always_comb begin
        stage0.valid = s0_valid_reg;
        stage0.err   = s0_err_reg;
        stage0.rdata = '0;
        if (s0_read_reg) begin
            stage0.rdata = ram_rdata;
        end else if (s0_err_reg) begin
            stage0.rdata = ERR_RDATA;
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        assign resp_out = stage0;
    end else begin : g_latn
        resp_t stage_reg [READ_LATENCY-1];

        for (genvar gi = 0; gi < READ_LATENCY - 1; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge HCLK or negedge HRESETn) begin
                    if (!HRESETn) stage_reg[gi] <= '0;
                    else          stage_reg[gi] <= stage0;
                end
            end else begin : g_next
                always_ff @(posedge HCLK or negedge HRESETn) begin
                    if (!HRESETn) stage_reg[gi] <= '0;
                    else          stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end

        assign resp_out = stage_reg[READ_LATENCY-2];
    end

    assign data_rvalid = resp_out.valid;
    assign data_err    = resp_out.err;
    assign data_rdata  = resp_out.rdata;

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Scoreboard bench for data_memory_pipelined at READ_LATENCY=3: a word model
// predicts each response at grant time and a monitor checks data and timing.
module tb_data_memory_pipelined;
    import dmem_pkg::*;

    localparam int    LAT  = 3;
    localparam word_t LOW  = 32'h0010_0000;
    localparam word_t HIGH = 32'h0010_8000;
    localparam word_t ERRD = 32'hDEAD_BEEF;

    logic  HCLK;
    logic  HRESETn;
    logic  data_req;
    logic  data_sel;
    word_t data_addr;
    logic  data_write;
    be_t   data_be;
    word_t data_wdata;
    logic  stall_i;
    logic  data_gnt;
    logic  data_rvalid;
    word_t data_rdata;
    logic  data_err;

    data_memory_pipelined #(
        .DMEM_ADDR_LOW  (LOW),
        .DMEM_ADDR_HIGH (HIGH),
        .DEPTH          (8192),
        .READ_LATENCY   (LAT),
        .ERR_RDATA      (ERRD)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .data_req    (data_req),
        .data_sel    (data_sel),
        .data_addr   (data_addr),
        .data_write  (data_write),
        .data_be     (data_be),
        .data_wdata  (data_wdata),
        .stall_i     (stall_i),
        .data_gnt    (data_gnt),
        .data_rvalid (data_rvalid),
        .data_rdata  (data_rdata),
        .data_err    (data_err)
    );

    typedef struct {
        logic  err;
        word_t rdata;
        int    cyc;
    } exp_t;

    exp_t  sb [$];
    word_t model [int];
    int    checks     = 0;
    int    errors     = 0;
    int    cyc        = 0;
    int    resp_count = 0;
    word_t last_rdata = '0;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc++;

    // Monitor: compare responses against the queue, then predict any new grant.
    always @(negedge HCLK) begin
        exp_t  e;
        word_t m;
        int    idx;
        if (!HRESETn) begin
            sb.delete();
        end else begin
            if (data_rvalid) begin
                resp_count++;
                last_rdata = data_rdata;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rvalid cycle=%0d got err=%0b rdata=%h, required no response",
                             cyc, data_err, data_rdata);
                end else begin
                    e = sb.pop_front();
                    if (data_err !== e.err || data_rdata !== e.rdata || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL response got err=%0b rdata=%h cycle=%0d, required err=%0b rdata=%h cycle=%0d",
                                 data_err, data_rdata, cyc, e.err, e.rdata, e.cyc);
                    end
                end
            end
            if (data_gnt === 1'b1) begin
                e.cyc = cyc + LAT;
                if (data_addr >= LOW && data_addr < HIGH) begin
                    idx   = int'((data_addr - LOW) >> 2);
                    e.err = 1'b0;
                    if (data_write) begin
                        m = model.exists(idx) ? model[idx] : 'x;
                        for (int b = 0; b < 4; b++) begin
                            if (data_be[b]) m[8*b +: 8] = data_wdata[8*b +: 8];
                        end
                        model[idx] = m;
                        e.rdata    = '0;
                    end else begin
                        e.rdata = model.exists(idx) ? model[idx] : 'x;
                    end
                end else begin
                    e.err   = 1'b1;
                    e.rdata = ERRD;
                end
                sb.push_back(e);
            end
        end
    end

    task automatic idle();
        data_req   = 1'b0;
        data_sel   = 1'b0;
        data_addr  = '0;
        data_write = 1'b0;
        data_be    = '0;
        data_wdata = '0;
        stall_i    = 1'b0;
    endtask

    // Drives one request starting just after a rising edge; leaves it driven for chaining.
    task automatic xfer(input logic wr, input word_t addr, input be_t be, input word_t wd);
        data_req   = 1'b1;
        data_sel   = 1'b1;
        stall_i    = 1'b0;
        data_write = wr;
        data_addr  = addr;
        data_be    = be;
        data_wdata = wd;
        @(negedge HCLK);
        checks++;
        if (data_gnt !== 1'b1) begin
            errors++;
            $display("FAIL gnt addr=%h got %0b required 1", addr, data_gnt);
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge HCLK);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending, required 0", sb.size());
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic check_last(input string name, input word_t req);
        checks++;
        if (last_rdata !== req) begin
            errors++;
            $display("FAIL %s got rdata=%h required %h", name, last_rdata, req);
        end
    endtask

    task automatic test_reset();
        idle();
        HRESETn = 1'b1;
        #1 HRESETn = 1'b0;
        repeat (3) begin
            @(negedge HCLK);
            checks++;
            if ({data_rvalid, data_err, data_rdata} !== 34'h0) begin
                errors++;
                $display("FAIL reset_outputs got rvalid=%0b err=%0b rdata=%h required 0 0 0",
                         data_rvalid, data_err, data_rdata);
            end
        end
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_write_read();
        xfer(1'b1, 32'h0010_0010, 4'hF, 32'hA5A5_5A5A);
        idle();
        drain();
        xfer(1'b0, 32'h0010_0010, 4'h0, '0);
        idle();
        drain();
        check_last("write_read", 32'hA5A5_5A5A);
    endtask

    task automatic test_byte_enable();
        xfer(1'b1, 32'h0010_0020, 4'hF, 32'h1122_3344);
        xfer(1'b1, 32'h0010_0020, 4'b0010, 32'h0000_BB00);
        xfer(1'b0, 32'h0010_0020, 4'h0, '0);
        idle();
        drain();
        check_last("byte_enable", 32'h1122_BB44);
        xfer(1'b1, 32'h0010_0020, 4'b0000, 32'hFFFF_FFFF);
        xfer(1'b0, 32'h0010_0020, 4'h0, '0);
        idle();
        drain();
        check_last("be_zero", 32'h1122_BB44);
    endtask

    task automatic test_back_to_back();
        int base;
        xfer(1'b1, 32'h0010_0030, 4'hF, 32'hCAFE_F00D);
        xfer(1'b0, 32'h0010_0030, 4'h0, '0);
        idle();
        drain();
        check_last("write_then_read", 32'hCAFE_F00D);
        base = resp_count;
        xfer(1'b0, 32'h0010_0010, 4'h0, '0);
        xfer(1'b0, 32'h0010_0020, 4'h0, '0);
        xfer(1'b0, 32'h0010_0030, 4'h0, '0);
        xfer(1'b0, 32'h0010_0010, 4'h0, '0);
        idle();
        drain();
        checks++;
        if (resp_count - base != 4) begin
            errors++;
            $display("FAIL back_to_back_count got %0d required 4", resp_count - base);
        end
    endtask

    task automatic test_out_of_range();
        xfer(1'b1, 32'h0010_0000, 4'hF, 32'h1357_9BDF);
        xfer(1'b0, 32'h0010_8000, 4'h0, '0);
        xfer(1'b1, 32'h0010_8000, 4'hF, 32'hFFFF_FFFF);
        xfer(1'b0, 32'h000F_FFFC, 4'h0, '0);
        xfer(1'b0, 32'h0010_0000, 4'h0, '0);
        idle();
        drain();
        check_last("oor_ram_unchanged", 32'h1357_9BDF);
    endtask

    task automatic test_stall();
        int base;
        base       = resp_count;
        data_req   = 1'b1;
        data_sel   = 1'b1;
        data_write = 1'b0;
        data_addr  = 32'h0010_0010;
        stall_i    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            checks++;
            if (data_gnt !== 1'b0) begin
                errors++;
                $display("FAIL stall_gnt cycle %0d got %0b required 0", i, data_gnt);
            end
            @(posedge HCLK);
            #1;
        end
        stall_i = 1'b0;
        @(negedge HCLK);
        checks++;
        if (data_gnt !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_gnt got %0b required 1", data_gnt);
        end
        @(posedge HCLK);
        #1;
        idle();
        drain();
        repeat (LAT + 2) @(posedge HCLK);
        #1;
        checks++;
        if (resp_count - base != 1) begin
            errors++;
            $display("FAIL stall_resp_count got %0d required 1", resp_count - base);
        end
    endtask

    task automatic test_no_sel();
        int base;
        base      = resp_count;
        data_req  = 1'b1;
        data_sel  = 1'b0;
        data_addr = 32'h0010_0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            checks++;
            if (data_gnt !== 1'b0) begin
                errors++;
                $display("FAIL nosel_gnt cycle %0d got %0b required 0", i, data_gnt);
            end
            @(posedge HCLK);
            #1;
        end
        idle();
        repeat (LAT + 3) @(posedge HCLK);
        #1;
        checks++;
        if (resp_count != base) begin
            errors++;
            $display("FAIL nosel_resp_count got %0d required %0d", resp_count, base);
        end
    endtask

    task automatic test_reset_midflight();
        int seen;
        xfer(1'b0, 32'h0010_0010, 4'h0, '0);
        xfer(1'b0, 32'h0010_0020, 4'h0, '0);
        HRESETn   = 1'b0;
        data_addr = 32'h0010_0030;
        for (int i = 0; i < 2; i++) begin
            @(negedge HCLK);
            checks++;
            if (data_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL rvalid_in_reset got %0b required 0", data_rvalid);
            end
            @(posedge HCLK);
            #1 data_addr = 32'h0010_0000;
        end
        idle();
        HRESETn = 1'b1;
        seen    = 0;
        repeat (6) begin
            @(negedge HCLK);
            if (data_rvalid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rvalid_after_reset got %0d responses required 0", seen);
        end
        @(posedge HCLK);
        #1;
        xfer(1'b0, 32'h0010_0010, 4'h0, '0);
        xfer(1'b0, 32'h0010_0020, 4'h0, '0);
        idle();
        drain();
        check_last("retained_after_reset", 32'h1122_BB44);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_back_to_back();
        test_out_of_range();
        test_stall();
        test_no_sel();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
